// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, NOP word and response record for imem_fetch
package imem_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam logic [DATA_W-1:0] NOP = 32'h00000000;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } rsp_t;
endpackage

// File: rtl/imem_rsp_fifo.sv
// imem_rsp_fifo: 2-entry registered response FIFO; a push is visible only after its edge
module imem_rsp_fifo
    import imem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic clear,
    input  rsp_t d,
    output rsp_t q,
    output logic full,
    output logic empty
);
    rsp_t       e [2];
    logic       wp, rp;
    logic [1:0] n;

    // storage and pointers; push and pop may both happen while full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e[0] <= '0;
            e[1] <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            n    <= 2'd0;
        end else if (clear) begin
            wp <= 1'b0;
            rp <= 1'b0;
            n  <= 2'd0;
        end else begin
            if (push)
                e[wp] <= d;
            wp <= wp ^ push;
            rp <= rp ^ pop;
            n  <= n + 2'(push) - 2'(pop);
        end
    end

    assign q     = e[rp];
    assign full  = n == 2'd2;
    assign empty = n == 2'd0;
endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: loadable instruction memory with valid/ready fetch port; IMEM_PARITY_EN adds per-word parity
module imem_fetch
    import imem_pkg::*;
#(
    parameter int DATA_W = imem_pkg::DATA_W,
    parameter int ADDR_W = imem_pkg::ADDR_W,
    parameter int DEPTH  = 64
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
    input  logic              load_par_flip,
`endif
    input  logic              flush
);
`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] word;
    logic [1:0]    cnt;
    logic          acc, pop, inr, full, empty, perr;
    rsp_t          wr, head;

    // a dequeue in the same cycle frees the slot an acceptance needs
    assign req_ready = rst_n && !load_en && !flush && ((cnt < 2'd2 && !full) || rsp_ready);
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign inr       = int'(req_addr) < DEPTH;
    assign word      = inr ? mem[req_addr] : '0;

    // even parity: a clean word xors to zero including its stored bit
`ifdef IMEM_PARITY_EN
    assign perr = ^word;
`else
    assign perr = 1'b0;
`endif

    // response captured from the array contents before the accept edge
    always_comb begin
        wr      = '0;
        wr.data = inr ? word[DATA_W-1:0] : NOP;
        wr.addr = req_addr;
        wr.err  = !inr || perr;
    end

    // boot-time loads; writes beyond DEPTH are dropped
    always_ff @(posedge clk) begin
        if (load_en && int'(load_addr) < DEPTH)
`ifdef IMEM_PARITY_EN
            mem[load_addr] <= {^load_data ^ load_par_flip, load_data};
`else
            mem[load_addr] <= load_data;
`endif
    end

    // outstanding fetches; flush discards everything on the fetch side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 2'd0;
        else if (flush)
            cnt <= 2'd0;
        else
            cnt <= cnt + 2'(acc) - 2'(pop);
    end

    imem_rsp_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (acc),
        .pop   (pop),
        .clear (flush),
        .d     (wr),
        .q     (head),
        .full  (full),
        .empty (empty)
    );

    assign rsp_valid = !empty;
    assign rsp_data  = head.data;
    assign rsp_addr  = head.addr;
    assign rsp_err   = head.err;
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed self-checking bench for imem_fetch (DEPTH=48)
module tb_imem_fetch;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err;
    logic [5:0]  req_addr = 0, rsp_addr, load_addr = 0;
    logic [31:0] rsp_data, load_data = 0;
    logic        load_en = 0, flush = 0, load_par_flip = 0;
    int          total = 0, bad = 0;

    imem_fetch #(.DATA_W(32), .ADDR_W(6), .DEPTH(48)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
`ifdef IMEM_PARITY_EN
        .load_par_flip (load_par_flip),
`endif
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic load(input logic [5:0] a, input logic [31:0] d, input logic f);
        load_en = 1; load_addr = a; load_data = d; load_par_flip = f;
        @(negedge clk);
        load_en = 0; load_par_flip = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", rsp_valid); end
        total++; if ({rsp_data, rsp_addr, rsp_err} !== 39'h0) begin bad++; $display("FAIL rst_outs got %h/%h/%b want 0", rsp_data, rsp_addr, rsp_err); end
        total++; if (dut.cnt !== 2'd0) begin bad++; $display("FAIL rst_cnt got %0d want 0", dut.cnt); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_load_fetch;
        load(6'd0, 32'h20020003, 0);
        load(6'd1, 32'h20070003, 0);
        rsp_ready = 1; req_valid = 1; req_addr = 6'd0;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lf_ready got %b want 1", req_ready); end
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err} !== {1'b1, 32'h20020003, 6'd0, 1'b0}) begin bad++; $display("FAIL lf_rsp0 got %b/%h/%0d/%b want 1/20020003/0/0", rsp_valid, rsp_data, rsp_addr, rsp_err); end
        req_addr = 6'd1;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err} !== {1'b1, 32'h20070003, 6'd1, 1'b0}) begin bad++; $display("FAIL lf_rsp1 got %b/%h/%0d/%b want 1/20070003/1/0", rsp_valid, rsp_data, rsp_addr, rsp_err); end
        req_valid = 0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || dut.cnt !== 2'd0) begin bad++; $display("FAIL lf_drain got %b/%0d want 0/0", rsp_valid, dut.cnt); end
    endtask

    task automatic test_backpressure;
        load(6'd2, 32'h11112222, 0);
        rsp_ready = 0; req_valid = 1; req_addr = 6'd0;
        @(negedge clk);
        total++; if (dut.cnt !== 2'd1) begin bad++; $display("FAIL bp_cnt1 got %0d want 1", dut.cnt); end
        req_addr = 6'd1;
        @(negedge clk);
        total++; if (dut.cnt !== 2'd2 || req_ready !== 1'b0) begin bad++; $display("FAIL bp_full got %0d/%b want 2/0", dut.cnt, req_ready); end
        req_addr = 6'd2;
        @(negedge clk);
        total++; if ({rsp_data, rsp_addr, req_ready} !== {32'h20020003, 6'd0, 1'b0}) begin bad++; $display("FAIL bp_hold got %h/%0d/%b want 20020003/0/0", rsp_data, rsp_addr, req_ready); end
        rsp_ready = 1;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got %b want 1", req_ready); end
        @(negedge clk);
        total++; if ({rsp_data, rsp_addr, dut.cnt} !== {32'h20070003, 6'd1, 2'd2}) begin bad++; $display("FAIL bp_second got %h/%0d/%0d want 20070003/1/2", rsp_data, rsp_addr, dut.cnt); end
        req_valid = 0;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr, dut.cnt} !== {1'b1, 32'h11112222, 6'd2, 2'd1}) begin bad++; $display("FAIL bp_third got %b/%h/%0d/%0d want 1/11112222/2/1", rsp_valid, rsp_data, rsp_addr, dut.cnt); end
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || dut.cnt !== 2'd0) begin bad++; $display("FAIL bp_drain got %b/%0d want 0/0", rsp_valid, dut.cnt); end
    endtask

    task automatic test_range;
        load(6'd47, 32'hdeadbeef, 0);
        load(6'd50, 32'hffffffff, 0);
        rsp_ready = 1; req_valid = 1; req_addr = 6'd50;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err} !== {1'b1, 32'h0, 6'd50, 1'b1}) begin bad++; $display("FAIL rng_oob got %b/%h/%0d/%b want 1/00000000/50/1", rsp_valid, rsp_data, rsp_addr, rsp_err); end
        req_addr = 6'd47;
        @(negedge clk);
        total++; if ({rsp_data, rsp_addr, rsp_err} !== {32'hdeadbeef, 6'd47, 1'b0}) begin bad++; $display("FAIL rng_last got %h/%0d/%b want deadbeef/47/0", rsp_data, rsp_addr, rsp_err); end
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_flush;
        rsp_ready = 0; req_valid = 1; req_addr = 6'd0;
        @(negedge clk);
        req_addr = 6'd1;
        @(negedge clk);
        total++; if (dut.cnt !== 2'd2) begin bad++; $display("FAIL fl_pre got %0d want 2", dut.cnt); end
        req_valid = 0; flush = 1;
        load_en = 1; load_addr = 6'd3; load_data = 32'h33334444;
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got %b want 0", req_ready); end
        @(negedge clk);
        flush = 0; load_en = 0;
        total++; if (rsp_valid !== 1'b0 || dut.cnt !== 2'd0) begin bad++; $display("FAIL fl_clear got %b/%0d want 0/0", rsp_valid, dut.cnt); end
        rsp_ready = 1; req_valid = 1; req_addr = 6'd3;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err} !== {1'b1, 32'h33334444, 6'd3, 1'b0}) begin bad++; $display("FAIL fl_next got %b/%h/%0d/%b want 1/33334444/3/0", rsp_valid, rsp_data, rsp_addr, rsp_err); end
        req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        rsp_ready = 0; req_valid = 1; req_addr = 6'd0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rm_pre got %b want 1", rsp_valid); end
        req_valid = 0;
        #2 rst_n = 0;
        #1;
        total++; if ({rsp_valid, rsp_data, rsp_addr, rsp_err, req_ready} !== 41'h0 || dut.cnt !== 2'd0) begin bad++; $display("FAIL rm_async got %b/%h/%0d/%b/%b/%0d want all 0", rsp_valid, rsp_data, rsp_addr, rsp_err, req_ready, dut.cnt); end
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1; req_valid = 1; req_addr = 6'd0;
        @(negedge clk);
        total++; if ({rsp_valid, rsp_data, rsp_addr} !== {1'b1, 32'h20020003, 6'd0}) begin bad++; $display("FAIL rm_after got %b/%h/%0d want 1/20020003/0", rsp_valid, rsp_data, rsp_addr); end
        req_valid = 0;
        @(negedge clk);
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity;
        load(6'd5, 32'hac63000a, 1);
        rsp_ready = 1; req_valid = 1; req_addr = 6'd5;
        @(negedge clk);
        total++; if ({rsp_data, rsp_err} !== {32'hac63000a, 1'b1}) begin bad++; $display("FAIL par_flip got %h/%b want ac63000a/1", rsp_data, rsp_err); end
        req_addr = 6'd1;
        @(negedge clk);
        total++; if ({rsp_data, rsp_err} !== {32'h20070003, 1'b0}) begin bad++; $display("FAIL par_clean got %h/%b want 20070003/0", rsp_data, rsp_err); end
        req_valid = 0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset;
        test_load_fetch;
        test_backpressure;
        test_range;
        test_flush;
        test_reset_mid;
`ifdef IMEM_PARITY_EN
        test_parity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
